// File: rtl/cotm32_pkg.sv
// Shared types and constants for the cotm32 memory-port arbiter.
package cotm32_pkg;

  localparam int XLEN             = 32;
  localparam int ARB_LAT_MAX      = 4;
  localparam int ARB_STARVE_LIMIT = 4;

  typedef enum logic {
    ARB_OWNER_IF = 1'b0,
    ARB_OWNER_LS = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic       valid;
    arb_owner_t owner;
    logic       is_write;
  } arb_slot_t;

endpackage

// File: rtl/arb_resp_pipe.sv
// LAT-deep response tracker: one slot per granted request, retired in grant
// order when the memory returns its data. A flush invalidates IF-owned slots.
module arb_resp_pipe
  import cotm32_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_flush,
  input  logic i_load_valid,
  input  logic i_load_ls,
  input  logic i_load_we,
  output logic o_if_ret,
  output logic o_ls_ret,
  output logic o_ls_ret_we
);

  arb_slot_t r_slot [LAT];
  arb_slot_t w_load;
  arb_slot_t w_ret;

  // Drop IF-owned entries while a flush is active; LS entries pass untouched.
  function automatic arb_slot_t flush_mask(input arb_slot_t s, input logic f);
    arb_slot_t m;
    m = s;
    if (f && (s.owner == ARB_OWNER_IF)) m.valid = 1'b0;
    return m;
  endfunction

  // Build the slot describing this cycle's grant.
  always_comb begin
    w_load          = '0;
    w_load.valid    = i_load_valid;
    w_load.owner    = i_load_ls ? ARB_OWNER_LS : ARB_OWNER_IF;
    w_load.is_write = i_load_we;
  end

  // Shift slots toward retirement; reset discards everything in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LAT; i++) r_slot[i] <= '0;
    end else begin
      r_slot[0] <= flush_mask(w_load, i_flush);
      for (int i = 1; i < LAT; i++) r_slot[i] <= flush_mask(r_slot[i-1], i_flush);
    end
  end

  assign w_ret       = r_slot[LAT-1];
  // A flush in the retiring cycle must suppress the IF response immediately.
  assign o_if_ret    = w_ret.valid && (w_ret.owner == ARB_OWNER_IF) && !i_flush;
  assign o_ls_ret    = w_ret.valid && (w_ret.owner == ARB_OWNER_LS);
  assign o_ls_ret_we = w_ret.is_write;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one pipelined single-port memory between instruction fetch (IF) and
// load-store (LS). LS wins by default; a starvation counter forces IF through
// after STARVE_LIMIT consecutive denials. Responses are routed by slot owner.
module mem_port_arbiter #(
  parameter int XLEN         = cotm32_pkg::XLEN,
  parameter int LAT          = 1,
  parameter int STARVE_LIMIT = cotm32_pkg::ARB_STARVE_LIMIT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_if_req,
  input  logic [XLEN-1:0]   i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [XLEN-1:0]   o_if_rdata,
  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [XLEN-1:0]   i_ls_addr,
  input  logic [XLEN-1:0]   i_ls_wdata,
  input  logic [XLEN/8-1:0] i_ls_wstrb,
  output logic              o_ls_gnt,
  output logic              o_ls_rvalid,
  output logic [XLEN-1:0]   o_ls_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_wstrb,
  input  logic [XLEN-1:0]   i_mem_rdata
);

  logic [3:0] r_starve_cnt;
  logic       w_starve_full;
  logic       w_force_if;
  logic       w_if_gnt;
  logic       w_ls_gnt;
  logic       w_mem_req;
  logic       w_if_ret;
  logic       w_ls_ret;
  logic       w_ls_ret_we;

  assign w_starve_full = (r_starve_cnt == 4'(STARVE_LIMIT));
  assign w_force_if    = w_starve_full && i_if_req;
  assign w_ls_gnt      = i_ls_req && !w_force_if;
  assign w_if_gnt      = i_if_req && (!i_ls_req || w_force_if);
  assign w_mem_req     = w_if_gnt || w_ls_gnt;

  assign o_if_gnt = w_if_gnt;
  assign o_ls_gnt = w_ls_gnt;

  // Route the granted requester onto the memory port; idle drives all zeros.
  always_comb begin
    o_mem_req   = w_mem_req;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wstrb = '0;
    if (w_ls_gnt) begin
      o_mem_we    = i_ls_we;
      o_mem_addr  = i_ls_addr;
      o_mem_wdata = i_ls_wdata;
      o_mem_wstrb = i_ls_wstrb;
    end else if (w_if_gnt) begin
      o_mem_addr  = i_if_addr;
    end
  end

  // Count consecutive denied IF cycles, saturating at the limit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve_cnt <= '0;
    end else if (i_flush || !i_if_req || w_if_gnt) begin
      r_starve_cnt <= '0;
    end else if (!w_starve_full) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  arb_resp_pipe #(
    .LAT (LAT)
  ) u_resp_pipe (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_flush      (i_flush),
    .i_load_valid (w_mem_req),
    .i_load_ls    (w_ls_gnt),
    .i_load_we    (w_ls_gnt && i_ls_we),
    .o_if_ret     (w_if_ret),
    .o_ls_ret     (w_ls_ret),
    .o_ls_ret_we  (w_ls_ret_we)
  );

  assign o_if_rvalid = w_if_ret;
  assign o_if_rdata  = w_if_ret ? i_mem_rdata : '0;
  assign o_ls_rvalid = w_ls_ret;
  assign o_ls_rdata  = (w_ls_ret && !w_ls_ret_we) ? i_mem_rdata : '0;

endmodule
